// File: rtl/umi_tx_splitter.sv
// umi_tx_splitter: breaks a wide UMI transaction (RATIO*DW data bits) into
// a sequence of DW-wide UMI packets, rewriting addresses, LEN and EOM per beat.
// Optional macro SB_UMI_SPLIT_BYPASS_EN: single-beat inputs arriving while the
// holding register is empty are forwarded combinationally with zero latency.
module umi_tx_splitter #(
  parameter int DW    = 256,
  parameter int RATIO = 4,
  parameter int AW    = 64,
  parameter int CW    = 32
) (
  input  logic                clk,
  input  logic                nreset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CW-1:0]       in_cmd,
  input  logic [AW-1:0]       in_dstaddr,
  input  logic [AW-1:0]       in_srcaddr,
  input  logic [RATIO*DW-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CW-1:0]       out_cmd,
  output logic [AW-1:0]       out_dstaddr,
  output logic [AW-1:0]       out_srcaddr,
  output logic [DW-1:0]       out_data
);

  localparam int OB   = DW / 8;
  localparam int IDW  = RATIO * DW;
  localparam int KW   = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int MAXB = RATIO * OB;

  typedef enum logic {IDLE, SEND} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]  cmd_q;
  logic [AW-1:0]  dst_q, src_q;
  logic [IDW-1:0] data_q;
  logic [31:0]    tbc_q;
  logic [KW-1:0]  k_q, last_q;
  logic           pass_q;

  logic [16:0]    in_tb;
  logic [31:0]    in_tbc;
  logic [KW-1:0]  in_last;
  logic           in_pass;

  logic           bypass, last_beat, fire, capture;

  logic [CW-1:0]  b_cmd;
  logic [AW-1:0]  b_dst, b_src;
  logic [DW-1:0]  b_slice;
  logic [31:0]    b_tbc;
  logic [KW-1:0]  b_k, b_last;
  logic           b_pass;

  logic [31:0]    off, rem, bb;
  logic [CW-1:0]  beat_cmd;
  logic [DW-1:0]  beat_data;

  // Decode total bytes (clamped to the input width), last beat index and the
  // oversize-element pass-through case for the transaction on the input port.
  always_comb begin
    in_tb   = (17'(in_cmd[15:8]) + 17'd1) << in_cmd[7:5];
    in_pass = (17'd1 << in_cmd[7:5]) > 17'(OB);
    in_tbc  = (32'(in_tb) > 32'(MAXB)) ? 32'(MAXB) : 32'(in_tb);
    in_last = in_pass ? '0 : KW'((in_tbc + 32'(OB) - 32'd1) / 32'(OB) - 32'd1);
  end

`ifdef SB_UMI_SPLIT_BYPASS_EN
  assign bypass = (state == IDLE) && (in_last == '0);
`else
  assign bypass = 1'b0;
`endif

  assign out_valid = bypass ? in_valid : (state == SEND);
  assign last_beat = (state == SEND) && (k_q == last_q);
  assign fire      = out_valid && out_ready;
  assign in_ready  = nreset && (bypass ? out_ready
                                       : ((state == IDLE) || (last_beat && out_ready)));
  assign capture   = in_valid && in_ready && !bypass;

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next state: leave SEND only when the last beat goes out with nothing new arriving.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (capture) state_nxt = SEND;
      SEND: if (fire && last_beat) state_nxt = capture ? SEND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Holding register and beat index: load on capture, step k after each non-last beat.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cmd_q  <= '0;
      dst_q  <= '0;
      src_q  <= '0;
      data_q <= '0;
      tbc_q  <= '0;
      k_q    <= '0;
      last_q <= '0;
      pass_q <= 1'b0;
    end else if (capture) begin
      cmd_q  <= in_cmd;
      dst_q  <= in_dstaddr;
      src_q  <= in_srcaddr;
      data_q <= in_data;
      tbc_q  <= in_tbc;
      k_q    <= '0;
      last_q <= in_last;
      pass_q <= in_pass;
    end else if (fire && (state == SEND) && !last_beat) begin
      k_q <= k_q + KW'(1);
    end
  end

  // Select the beat source: the holding register, or the live input when bypassing.
  always_comb begin
    b_slice = '0;
    for (int i = 0; i < RATIO; i++)
      if (k_q == KW'(i)) b_slice = data_q[i*DW +: DW];
    b_cmd  = cmd_q;
    b_dst  = dst_q;
    b_src  = src_q;
    b_tbc  = tbc_q;
    b_k    = k_q;
    b_last = last_q;
    b_pass = pass_q;
    if (bypass) begin
      b_slice = in_data[DW-1:0];
      b_cmd   = in_cmd;
      b_dst   = in_dstaddr;
      b_src   = in_srcaddr;
      b_tbc   = in_tbc;
      b_k     = '0;
      b_last  = '0;
      b_pass  = in_pass;
    end
  end

  // Build beat k: offset addresses, per-beat LEN/EOM, zero bytes past the payload end.
  always_comb begin
    off       = 32'(b_k) * 32'(OB);
    rem       = b_tbc - off;
    bb        = (rem < 32'(OB)) ? rem : 32'(OB);
    beat_cmd  = b_cmd;
    beat_data = b_slice;
    if (!b_pass) begin
      beat_cmd[15:8] = 8'((bb >> b_cmd[7:5]) - 32'd1);
      beat_cmd[22]   = (b_k == b_last) ? b_cmd[22] : 1'b0;
      for (int j = 0; j < OB; j++)
        if (32'(j) >= bb) beat_data[j*8 +: 8] = 8'h00;
    end
    out_cmd     = out_valid ? beat_cmd : '0;
    out_dstaddr = out_valid ? (b_dst + AW'(off)) : '0;
    out_srcaddr = out_valid ? (b_src + AW'(off)) : '0;
    out_data    = out_valid ? beat_data : '0;
  end

endmodule

// File: doc/umi_tx_splitter.md
# umi_tx_splitter

Splits wide UMI transactions into narrow, fixed-width beats for the switchboard TX path. It sits directly upstream of the UMI-to-queue simulation bridge, which carries at most DW bits of data per packet. A transaction whose payload exceeds one output beat becomes a sequence of legal UMI packets, in order, with the following fields updated per beat:
- addresses
- LEN
- EOM

## Interface
- `DW`, 256: output data width in bits; OB = DW/8 bytes per output beat.
- `RATIO`, 4: input/output width ratio; input data width IDW = RATIO*DW. Power of two, 1..16.
- `AW`, 64: address width.
- `CW`, 32: command width.

Ports:
- `clk`  input  1  clock; all logic on the rising edge.
- `nreset`  input  1  reset, asynchronous and active-low.
- `in_valid`  input  1  input transaction valid.
- `in_ready`  output  1  input accepted when `in_valid && in_ready`.
- `in_cmd`  input  CW  UMI command.
- `in_dstaddr`  input  AW  destination address.
- `in_srcaddr`  input  AW  source address.
- `in_data`  input  IDW  payload; byte 0 in `[7:0]`.
- `out_valid`  output  1  output beat valid.
- `out_ready`  input  1  downstream ready; beat transfers when `out_valid && out_ready`.
- `out_cmd`  output  CW  per-beat command.
- `out_dstaddr`  output  AW  per-beat destination.
- `out_srcaddr`  output  AW  per-beat source.
- `out_data`  output  DW  per-beat payload.

## Operation
- UMI command fields:
  - OPCODE `cmd[4:0]`
  - SIZE `cmd[7:5]`
  - LEN `cmd[15:8]`
  - EOM `cmd[22]`
  - all other bits pass through unchanged.
- Transaction bytes are computed as TB = (LEN+1) << SIZE, in 17-bit arithmetic. Beat count is NB = ceil(TB/OB).
- If TB > RATIO*OB, NB is clamped to RATIO and the excess bytes are dropped.
- All opcodes are split identically. Requests without data still split, so that address and LEN stay consistent.
- States:
  - IDLE: holding register empty.
  - SEND: holding register full; beat index k runs 0..NB-1.
- Transitions:
  - IDLE -> SEND when an input is accepted; the transaction is captured and k=0.
  - SEND, non-last beat transferred: k <= k+1.
  - SEND, last beat transferred: go to IDLE, or capture a new transaction and stay in SEND with k=0 if `in_valid` is high the same cycle.
- Beat k fields:
  - `out_dstaddr` = dstaddr + k*OB, and `out_srcaddr` = srcaddr + k*OB. Both wrap modulo 2^AW.
  - Beat bytes BB = min(OB, TB_clamped - k*OB). `out_cmd` LEN = (BB >> SIZE) - 1.
  - EOM = input EOM on the last beat only, 0 on all earlier beats.
  - `out_data` = `in_data[k*DW +: DW]`. Bytes at and above BB in the final beat are forced to zero.
- Inputs with SIZE such that (1<<SIZE) > OB are passed through as a single beat, with cmd, addresses and `in_data[DW-1:0]` unmodified.

## Timing
- Reset values:
  - `out_valid`=0; state IDLE, k=0.
  - Output data, address and cmd registers = 0.
  - `in_ready`=0 while `nreset` is low.
- `in_ready` = (state==IDLE) or (last beat transferring this cycle). This gives back-to-back throughput of one beat per cycle with no bubble between transactions.
- Latency: first beat appears the cycle after input acceptance.
- `out_valid` holds until transfer. Outputs must stay stable while `out_valid && !out_ready`.
- A transaction occupies NB consecutive cycles when `out_ready` is held high.
- `nreset` asserted mid-transaction clears state immediately. Remaining beats are discarded, and no partial EOM is emitted after release.

## Configuration
- `SB_UMI_SPLIT_BYPASS_EN`, when defined: in IDLE, with the holding register empty and the input needing exactly one beat (NB==1):
  - the input is forwarded combinationally: `out_*` = `in_*` with the data slice, `out_valid`=`in_valid`, `in_ready`=`out_ready`.
  - Latency is zero and no register is loaded.
  - Multi-beat inputs behave as without the macro.
- Not defined: every transaction, including single-beat ones, passes through the holding register with one-cycle latency.

## Test plan
- DW=256, RATIO=4, SIZE=0, LEN=31, dst=0x1000, `out_ready`=1 -> one beat, LEN=31, dst=0x1000, EOM copied, data = `in_data[255:0]`, at cycle +1.
- SIZE=0, LEN=127, dst=0x1000, src=0x2000, EOM=1 -> 4 beats:
  - dst 0x1000/0x1020/0x1040/0x1060 and src 0x2000..0x2060, each LEN=31.
  - EOM=0,0,0,1.
  - `in_ready` high on the 4th beat.
- SIZE=2, LEN=11 (TB=48) -> 2 beats: LEN=7 then LEN=3; second beat data bytes 16..31 = 0.
- `out_ready` toggled 1,0,0,1 mid-transaction -> outputs stable during stall; no beat lost or duplicated; two transactions issued back-to-back show no idle cycle between them.
- dst=0xFFFF_FFFF_FFFF_FFE0, 2 beats -> second beat dst=0x0; `nreset` pulsed low after beat 1 -> `out_valid`=0 and IDLE after release, no further beats.
- LEN=255, SIZE=1 (TB=512 > 128) -> 4 beats only, last EOM set; with the bypass macro, a single-beat input appears at the output in the same cycle.
